// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DISCARD,
      HALT
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            ebreak;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr, ebreak} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           pc_i,
   input  logic [WIDTH-1:0]           instr_i,
   input  logic                       ebreak_i,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [WIDTH-1:0]           pc_o,
   output logic [WIDTH-1:0]           instr_o,
   output logic                       ebreak_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] pc_mem    [DEPTH];
   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic             ebrk_mem  [DEPTH];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clr_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + (AW+1)'(1);
         if (pop_i)  rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clr_i) begin
         pc_mem[wr_q[AW-1:0]]    <= pc_i;
         instr_mem[wr_q[AW-1:0]] <= instr_i;
         ebrk_mem[wr_q[AW-1:0]]  <= ebreak_i;
      end
   end

   assign count_o  = wr_q - rd_q;
   assign valid_o  = (count_o != '0);
   assign pc_o     = pc_mem[rd_q[AW-1:0]];
   assign instr_o  = instr_mem[rd_q[AW-1:0]];
   assign ebreak_o = ebrk_mem[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, issues one word read at a time and buffers
// results for decode; redirect flushes, ebreak halts until redirected.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int unsigned       WIDTH    = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(32'h8000_0000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [WIDTH-1:0] mem_req_addr,
   input  logic             mem_rsp_valid,
   input  logic [WIDTH-1:0] mem_rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instr,
   output logic             out_ebreak,
   output logic             halted
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             push, pop;
   logic             req_fire;
   logic             rsp_ebreak;

   assign fifo_full  = (fifo_count == CW'(DEPTH));
   assign rsp_ebreak = (mem_rsp_data == WIDTH'(EBREAK_INSTR));

   // Requests wait for a free slot so a returning response always fits.
   assign mem_req_valid = (state_q == FETCH) && !fifo_full && !rst;
   assign mem_req_addr  = pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;
   assign halted        = (state_q == HALT);
   assign pop           = out_valid && out_ready && !redirect_valid;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      if (redirect_valid) begin
         pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
         if (req_fire ||
             (state_q inside {WAIT, DISCARD} && !mem_rsp_valid))
            state_d = DISCARD;
         else
            state_d = FETCH;
      end else begin
         unique case (state_q)
            FETCH:   if (req_fire) state_d = WAIT;
            WAIT: begin
               if (mem_rsp_valid) begin
                  push    = 1'b1;
                  pc_d    = pc_q + WIDTH'(PC_INC);
                  state_d = rsp_ebreak ? HALT : FETCH;
               end
            end
            DISCARD: if (mem_rsp_valid) state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (redirect_valid),
      .push_i   (push),
      .pop_i    (pop),
      .pc_i     (pc_q),
      .instr_i  (mem_rsp_data),
      .ebreak_i (rsp_ebreak),
      .valid_o  (out_valid),
      .count_o  (fifo_count),
      .pc_o     (out_pc),
      .instr_o  (out_instr),
      .ebreak_o (out_ebreak)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench: in-order memory model with programmable latency,
// request and delivery logs checked against hand-computed sequences.
module tb_fetch_prefetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ebreak;
   logic        halted;

   int          n_chk = 0;
   int          n_pass = 0;
   int          lat = 1;
   logic [31:0] ebreak_at = '0;
   logic [31:0] req_q[$];
   fetch_entry_t out_q[$];

   fetch_prefetch dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ebreak     (out_ebreak),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a == ebreak_at) ? EBREAK_INSTR : (a ^ 32'h1234_0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // In-order memory, one outstanding read, response after lat cycles.
   logic        m_hs, m_pend;
   logic [31:0] m_ha, m_paddr;
   int          m_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_rsp_valid = 1'b0;
         m_pend = 1'b0;
      end else begin
         m_hs = mem_req_valid && mem_req_ready;
         m_ha = mem_req_addr;
         #1;
         mem_rsp_valid = 1'b0;
         if (m_hs) begin
            m_pend = 1'b1;
            m_cnt = lat;
            m_paddr = m_ha;
            req_q.push_back(m_ha);
         end
         if (m_pend) begin
            m_cnt--;
            if (m_cnt <= 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data = mdata(m_paddr);
               m_pend = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !redirect_valid)
         out_q.push_back('{pc: out_pc, instr: out_instr, ebreak: out_ebreak});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      for (int i = 0; i < 200 && out_q.size() < n; i++) tick(1);
      chk("out_count", out_q.size(), n);
   endtask

   int rb, ob;

   initial begin
      // Reset values and first-output latency
      tick(1);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      out_ready = 1'b1;
      rb = req_q.size(); ob = out_q.size();
      do_reset();
      tick(1);
      chk("lat_out_valid_c1", out_valid, 0);
      tick(1);
      chk("lat_out_valid_c2", out_valid, 1);
      chk("lat_out_pc", out_pc, 32'h8000_0000);
      wait_outs(ob + 3);
      for (int i = 0; i < 3; i++) begin
         chk("seq_req", req_q[rb+i], 32'h8000_0000 + 4*i);
         chk("seq_pc", out_q[ob+i].pc, 32'h8000_0000 + 4*i);
         chk("seq_instr", out_q[ob+i].instr, (32'h8000_0000 + 4*i) ^ 32'h1234_0000);
      end

      // Backpressure: exactly DEPTH fetched, then resume
      out_ready = 1'b0;
      do_reset();
      rb = req_q.size(); ob = out_q.size();
      tick(12);
      chk("bp_req_count", req_q.size() - rb, 4);
      chk("bp_req_valid", mem_req_valid, 0);
      chk("bp_out_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_outs(ob + 8);
      for (int i = 0; i < 8; i++) begin
         chk("bp_req", req_q[rb+i], 32'h8000_0000 + 4*i);
         chk("bp_pc", out_q[ob+i].pc, 32'h8000_0000 + 4*i);
      end

      // Redirect while a response is outstanding
      lat = 3;
      do_reset();
      rb = req_q.size(); ob = out_q.size();
      tick(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      tick(1);
      redirect_valid = 1'b0;
      chk("rd_discard_req_valid", mem_req_valid, 0);
      chk("rd_discard_out_valid", out_valid, 0);
      tick(2);
      chk("rd_req_valid", mem_req_valid, 1);
      chk("rd_req_addr", mem_req_addr, 32'h8000_0100);
      wait_outs(ob + 1);
      chk("rd_first_pc", out_q[ob].pc, 32'h8000_0100);
      chk("rd_first_instr", out_q[ob].instr, 32'h8000_0100 ^ 32'h1234_0000);
      chk("rd_req_log", req_q[rb+1], 32'h8000_0100);

      // Ebreak halts fetching until redirected
      lat = 1;
      ebreak_at = 32'h8000_000C;
      do_reset();
      rb = req_q.size(); ob = out_q.size();
      tick(16);
      chk("eb_halted", halted, 1);
      chk("eb_req_valid", mem_req_valid, 0);
      chk("eb_req_count", req_q.size() - rb, 4);
      chk("eb_out_count", out_q.size() - ob, 4);
      chk("eb_last_pc", out_q[ob+3].pc, 32'h8000_000C);
      chk("eb_last_flag", out_q[ob+3].ebreak, 1);
      chk("eb_prev_flag", out_q[ob+2].ebreak, 0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0002;
      tick(1);
      redirect_valid = 1'b0;
      chk("eb_unhalt", halted, 0);
      chk("eb_resume_valid", mem_req_valid, 1);
      chk("eb_resume_addr", mem_req_addr, 32'h8000_0000);
      ebreak_at = '0;

      // Stalled request stays stable; redirect retargets it
      mem_req_ready = 1'b0;
      do_reset();
      rb = req_q.size();
      for (int i = 0; i < 5; i++) begin
         redirect_valid = (i == 2);
         redirect_pc = 32'h8000_0200;
         tick(1);
         chk("st_valid", mem_req_valid, 1);
         chk("st_addr", mem_req_addr, (i >= 2) ? 32'h8000_0200 : 32'h8000_0000);
      end
      redirect_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick(2);
      chk("st_req_log", req_q[rb], 32'h8000_0200);

      // Asynchronous reset in the middle of WAIT
      out_ready = 1'b0;
      do_reset();
      tick(4);
      lat = 3;
      tick(1);
      chk("ar_pre_out_valid", out_valid, 1);
      chk("ar_pre_req_addr", mem_req_addr, 32'h8000_0008);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_req_valid", mem_req_valid, 0);
      chk("ar_req_addr", mem_req_addr, 32'h8000_0000);
      chk("ar_halted", halted, 0);
      lat = 1;
      out_ready = 1'b1;
      ob = out_q.size();
      do_reset();
      wait_outs(ob + 2);
      chk("ar_restart_pc0", out_q[ob].pc, 32'h8000_0000);
      chk("ar_restart_pc1", out_q[ob+1].pc, 32'h8000_0004);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Next-generation instruction fetch stage: owns the PC register and issues word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers fetched {pc, instr} pairs in a parametrised FIFO and presents them to decode over a valid/ready handshake.
- Supports control-flow redirect with flush of buffered and in-flight instructions.
- Detects ebreak at fetch and halts further fetching until redirected.

Parameters:
- WIDTH, 32, address and instruction width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h80000000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  new fetch address; bits [1:0] are ignored and treated as 0.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  WIDTH  word-aligned read address.
- mem_rsp_valid  in  1  read data valid; responses return in order, at most one per cycle.
- mem_rsp_data  in  WIDTH  instruction word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode consumes the head.
- out_pc  out  WIDTH  PC of the head entry.
- out_instr  out  WIDTH  instruction of the head entry.
- out_ebreak  out  1  head instruction equals 32'h00100073.
- halted  out  1  fetch is stopped on an ebreak.

Behaviour:
- Reset (async, while rst=1): fetch_pc=RESET_PC, FIFO empty, outstanding=0, state=FETCH. All outputs are 0, except mem_req_addr=RESET_PC.
- State machine states: FETCH, WAIT, DISCARD, HALT. At most one request is outstanding.
- FETCH:
  - mem_req_valid=1 when count < DEPTH, so the in-flight slot is reserved.
  - On a valid&ready handshake, go to WAIT.
  - mem_req_valid and mem_req_addr stay stable until accepted. A redirect is the only thing that may change them.
- WAIT:
  - On mem_rsp_valid, push {fetch_pc, mem_rsp_data, ebreak flag} and set fetch_pc += 4. Fetch_pc wraps modulo 2^WIDTH.
  - If the pushed instruction is ebreak, go to HALT; otherwise go to FETCH.
  - The next request may issue the cycle after the response arrives (2-cycle minimum per instruction with zero-wait memory).
- DISCARD: the in-flight response is dropped with no push. Then go to FETCH at the already-loaded redirect_pc.
- HALT:
  - mem_req_valid=0 and halted=1.
  - The FIFO continues to drain to decode.
  - Leaves HALT only on redirect.
- Redirect (redirect_valid=1), highest priority, any state:
  - FIFO is cleared the next cycle; a pop in the same cycle is ignored.
  - fetch_pc is set to redirect_pc and halted is cleared.
  - A response arriving in the same cycle is dropped.
  - If a request is still outstanding after this cycle (WAIT without a response, or a request accepted this cycle), go to DISCARD; otherwise go to FETCH.
- FIFO:
  - out_* is driven combinationally from the head.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is allowed at any count, including full-reserved.
  - Overflow cannot occur because of the reservation rule; underflow cannot occur because pop is qualified by valid.
- Reset mid-operation: an outstanding response arriving after rst falls is not expected. The memory must be reset by the same rst.
- Latency: first out_valid rises no earlier than 2 cycles after rst deasserts with zero-wait memory (request cycle, then response cycle, then visible).

Decomposition:
- Package fetch_pkg:
  - state enum (FETCH, WAIT, DISCARD, HALT).
  - EBREAK_INSTR = 32'h00100073.
  - PC increment constant 4.
  - FIFO entry struct {pc, instr, ebreak}.
- Sub-module fetch_fifo: parametrised by WIDTH and DEPTH. Synchronous FIFO with clear, push, pop, count and head outputs, using wrap-around pointers plus an extra bit to tell full from empty.

Test Plan:
- Reset, zero-wait memory returning addr-derived words, out_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; outputs in order with matching pc/instr.
- out_ready=0 with DEPTH=4 → exactly 4 entries fetched, mem_req_valid held 0; raise out_ready → fetching resumes with no loss or duplication.
- Redirect to 0x80000100 while a response is outstanding (3-cycle latency) → stale response discarded, FIFO empty, next request at 0x80000100, first output pc=0x80000100.
- Fetch stream containing 32'h00100073 at 0x8000000C → entry delivered with out_ebreak=1, halted=1, no request for 0x80000010; redirect to 0x80000000 clears halted and resumes.
- mem_req_ready low for 5 cycles → mem_req_valid and mem_req_addr stable throughout; redirect in cycle 3 changes addr to redirect_pc.
- Assert rst asynchronously mid-WAIT → outputs cleared immediately, restart at RESET_PC after release.
